voice_allocator: RTL and testbench
==================================

# voice_allocator

Voice allocator for the polyphonic synthesizer core. It accepts decoded MIDI note events (note-on, note-off, sustain) from the MIDI front end over a valid/ready handshake. It decides which voice slot of the shared voice array plays each note and drives the per-voice gate vector (`keys_on`) and assignment strobes consumed by the oscillator/envelope datapath. Voice selection runs as a sequential scan over the voice table, one voice per clock.

## Interface
- `VOICES`, 32, number of voice slots
- `V_WIDTH`, 4, MSB index of a voice number (voice index is `V_WIDTH+1` bits)
- `reg_clk` in 1: the only clock
- `reset_reg_n` in 1: asynchronous, active-low reset
- `ev_valid` in 1: event present
- `ev_ready` out 1: allocator idle, event accepted when `ev_valid & ev_ready` at a clock edge
- `ev_type` in 2: 0 = note-on, 1 = note-off, 2 = sustain, 3 = all-notes-off
- `ev_key` in 7: MIDI key number
- `ev_vel` in 7: velocity; for sustain, bit 6 = pedal down
- `voice_free` in VOICES: 1 = envelope of that voice has finished release (from datapath)
- `keys_on` out VOICES: gate per voice
- `assign_valid` out 1: one-cycle strobe, note-on assigned
- `assign_voice` out V_WIDTH+1: voice index assigned
- `assign_key` out 7, `assign_vel` out 7: note for the assigned voice
- `assign_steal` out 1: assignment pre-empted a sounding voice
- `active_keys` out V_WIDTH+2: population count of `keys_on`

## Operation
- Voice table per slot: `key[6:0]`, `held` (= `keys_on` bit), `sust` (released while pedal down), `age[V_WIDTH:0]`.
- A note-on with `ev_vel == 0` is treated as a note-off.
- FSM states:
  - IDLE: `ev_ready=1`.
    - Accept note-on/note-off → SCAN with index 0.
    - Accept sustain/all-off → APPLY.
  - SCAN: one slot per cycle, index 0..VOICES-1. Tracks:
    - first slot whose `key` matches and which is held or sustained (`match`);
    - lowest-index slot with `voice_free=1` and `held=0` and `sust=0` (`free`);
    - slot with maximum `age`, lowest index on tie (`oldest`).
    - After index VOICES-1 → COMMIT.
  - COMMIT: one cycle, then IDLE. Note-on target priority: `match` (retrigger, `assign_steal=0`), else `free` (`assign_steal=0`), else `oldest` (`assign_steal=1`). On a note-on COMMIT:
    - target gets `key`, `held=1`, `sust=0`, `age=0`;
    - every other held or sustained slot increments `age`, saturating at VOICES-1;
    - `assign_*` outputs are loaded and `assign_valid` pulses.
  - Note-off COMMIT:
    - if `match` exists: pedal down → `held=0`, `sust=1`; pedal up → `held=0`;
    - if no `match`: event dropped, no output change.
  - APPLY: one cycle, then IDLE.
    - Sustain down: sets internal pedal flag.
    - Sustain up: clears the pedal flag and clears `sust` on all slots.
    - All-notes-off: clears `held` and `sust` on all slots and clears the pedal flag.
- `voice_free` is sampled per slot at that slot's scan cycle. Changes after that cycle are ignored until the next event.
- `active_keys` is the registered popcount of the new `keys_on`, updated on the same edge.

## Timing
- Reset values:
  - `ev_ready=1`, `keys_on=0`, `assign_valid=0`, `assign_voice=0`, `assign_key=0`, `assign_vel=0`, `assign_steal=0`, `active_keys=0`;
  - all table fields 0; pedal flag 0; FSM state IDLE.
- Acceptance edge E0:
  - Note events: SCAN occupies E0+1..E0+VOICES. COMMIT updates take effect at edge E0+VOICES+1; `assign_valid` is high for exactly the cycle after that edge. `ev_ready` returns to 1 on the same edge.
  - Note-on to `keys_on` latency: VOICES+1 edges.
  - Sustain/all-off: state updates at E0+1. `ev_ready` is high again from E0+1.
- `ev_ready` is 0 from E0 until the return to IDLE. Input fields are captured at E0 and may change afterwards.
- `assign_valid` never asserts for note-off, sustain or all-off.
- Reset asserted mid-scan/commit: the event is lost, all outputs take reset values asynchronously, and nothing is committed.
- Age saturation: repeated assignments never wrap `age`.

## Test plan
- Reset, then note-on key 60 vel 100 with all `voice_free=1` → after 33 edges `assign_valid` pulses once with voice 0, key 60, vel 100, steal 0; `keys_on=0x00000001`, `active_keys=1`.
- Note-on 60, 62, 64 → voices 0, 1, 2. Note-off 62 → `keys_on=0x00000005`, `active_keys=2`. Note-off 70 (unmatched) → no change.
- Retrigger: note-on 60 twice → both assignments use voice 0 and `active_keys` stays 1.
- Voice stealing: 32 note-ons on keys 0..31, then with `voice_free=0` a note-on for key 40 → assigned voice 0 (oldest), `assign_steal=1`, `keys_on` all ones.
- Sustain: pedal down, note-on 60, note-off 60 → `keys_on[0]=0`; a new note-on 61 with `voice_free[0]=1` skips voice 0 and takes voice 1. Pedal up → voice 0 becomes allocatable.
- Assert reset 5 cycles into a scan → all outputs read reset values, no `assign_valid`, and `ev_ready=1` after release.

Source files
------------

// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note event stream and voice assignment strobe bundle
interface voice_allocator_if #(
    parameter int V_WIDTH = 4
);
    logic             ev_valid;
    logic             ev_ready;
    logic [1:0]       ev_type;
    logic [6:0]       ev_key;
    logic [6:0]       ev_vel;
    logic             assign_valid;
    logic [V_WIDTH:0] assign_voice;
    logic [6:0]       assign_key;
    logic [6:0]       assign_vel;
    logic             assign_steal;

    modport master (
        output ev_valid, ev_type, ev_key, ev_vel,
        input  ev_ready,
        input  assign_valid, assign_voice, assign_key, assign_vel, assign_steal
    );
    modport slave (
        input  ev_valid, ev_type, ev_key, ev_vel,
        output ev_ready,
        output assign_valid, assign_voice, assign_key, assign_vel, assign_steal
    );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator with sequential voice-table scan
module voice_allocator #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = 4
) (
    input  logic               reg_clk,
    input  logic               reset_reg_n,
    voice_allocator_if.slave   ev,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  keys_on,
    output logic [V_WIDTH+1:0] active_keys
);
    localparam int            IW       = V_WIDTH + 1;
    localparam logic [IW-1:0] AGE_MAX  = IW'(VOICES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(VOICES - 1);
    localparam logic [1:0]    OP_ON    = 2'd0;
    localparam logic [1:0]    OP_OFF   = 2'd1;
    localparam logic [1:0]    OP_SUST  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_APPLY} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [1:0]         op_q, op_d;
    logic [6:0]         op_key_q, op_key_d;
    logic [6:0]         op_vel_q, op_vel_d;
    logic               pedal_q, pedal_d;
    logic               match_ok_q, match_ok_d;
    logic               free_ok_q, free_ok_d;
    logic [IW-1:0]      match_idx_q, match_idx_d;
    logic [IW-1:0]      free_idx_q, free_idx_d;
    logic [IW-1:0]      old_idx_q, old_idx_d;
    logic [IW-1:0]      old_age_q, old_age_d;
    logic [6:0]         key_q [VOICES];
    logic [6:0]         key_d [VOICES];
    logic [IW-1:0]      age_q [VOICES];
    logic [IW-1:0]      age_d [VOICES];
    logic [VOICES-1:0]  held_q, held_d;
    logic [VOICES-1:0]  sust_q, sust_d;
    logic               assign_valid_q, assign_valid_d;
    logic [IW-1:0]      assign_voice_q, assign_voice_d;
    logic [6:0]         assign_key_q, assign_key_d;
    logic [6:0]         assign_vel_q, assign_vel_d;
    logic               assign_steal_q, assign_steal_d;
    logic [V_WIDTH+1:0] active_q, active_d;
    logic [IW-1:0]      tgt;

    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            op_q           <= '0;
            op_key_q       <= '0;
            op_vel_q       <= '0;
            pedal_q        <= 1'b0;
            match_ok_q     <= 1'b0;
            free_ok_q      <= 1'b0;
            match_idx_q    <= '0;
            free_idx_q     <= '0;
            old_idx_q      <= '0;
            old_age_q      <= '0;
            held_q         <= '0;
            sust_q         <= '0;
            assign_valid_q <= 1'b0;
            assign_voice_q <= '0;
            assign_key_q   <= '0;
            assign_vel_q   <= '0;
            assign_steal_q <= 1'b0;
            active_q       <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            op_q           <= op_d;
            op_key_q       <= op_key_d;
            op_vel_q       <= op_vel_d;
            pedal_q        <= pedal_d;
            match_ok_q     <= match_ok_d;
            free_ok_q      <= free_ok_d;
            match_idx_q    <= match_idx_d;
            free_idx_q     <= free_idx_d;
            old_idx_q      <= old_idx_d;
            old_age_q      <= old_age_d;
            held_q         <= held_d;
            sust_q         <= sust_d;
            assign_valid_q <= assign_valid_d;
            assign_voice_q <= assign_voice_d;
            assign_key_q   <= assign_key_d;
            assign_vel_q   <= assign_vel_d;
            assign_steal_q <= assign_steal_d;
            active_q       <= active_d;
            for (int i = 0; i < VOICES; i++) begin
                key_q[i] <= key_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        op_d           = op_q;
        op_key_d       = op_key_q;
        op_vel_d       = op_vel_q;
        pedal_d        = pedal_q;
        match_ok_d     = match_ok_q;
        free_ok_d      = free_ok_q;
        match_idx_d    = match_idx_q;
        free_idx_d     = free_idx_q;
        old_idx_d      = old_idx_q;
        old_age_d      = old_age_q;
        held_d         = held_q;
        sust_d         = sust_q;
        assign_valid_d = 1'b0;
        assign_voice_d = assign_voice_q;
        assign_key_d   = assign_key_q;
        assign_vel_d   = assign_vel_q;
        assign_steal_d = assign_steal_q;
        tgt            = '0;
        active_d       = '0;
        for (int i = 0; i < VOICES; i++) begin
            key_d[i] = key_q[i];
            age_d[i] = age_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (ev.ev_valid) begin
                    // zero-velocity note-on is the running-status form of note-off
                    op_d        = (ev.ev_type == OP_ON && ev.ev_vel == 7'd0) ? OP_OFF : ev.ev_type;
                    op_key_d    = ev.ev_key;
                    op_vel_d    = ev.ev_vel;
                    idx_d       = '0;
                    match_ok_d  = 1'b0;
                    free_ok_d   = 1'b0;
                    match_idx_d = '0;
                    free_idx_d  = '0;
                    old_idx_d   = '0;
                    old_age_d   = '0;
                    state_d     = (ev.ev_type[1] == 1'b0) ? S_SCAN : S_APPLY;
                end
            end
            S_SCAN: begin
                if (!match_ok_q && key_q[idx_q] == op_key_q && (held_q[idx_q] || sust_q[idx_q])) begin
                    match_ok_d  = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!free_ok_q && voice_free[idx_q] && !held_q[idx_q] && !sust_q[idx_q]) begin
                    free_ok_d  = 1'b1;
                    free_idx_d = idx_q;
                end
                // strict compare keeps the lowest index on equal ages
                if (age_q[idx_q] > old_age_q) begin
                    old_age_d = age_q[idx_q];
                    old_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) state_d = S_COMMIT;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (op_q == OP_ON) begin
                    tgt = match_ok_q ? match_idx_q : (free_ok_q ? free_idx_q : old_idx_q);
                    for (int i = 0; i < VOICES; i++) begin
                        if ((held_q[i] || sust_q[i]) && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
                    end
                    key_d[tgt]     = op_key_q;
                    held_d[tgt]    = 1'b1;
                    sust_d[tgt]    = 1'b0;
                    age_d[tgt]     = '0;
                    assign_valid_d = 1'b1;
                    assign_voice_d = tgt;
                    assign_key_d   = op_key_q;
                    assign_vel_d   = op_vel_q;
                    assign_steal_d = !match_ok_q && !free_ok_q;
                end else if (match_ok_q) begin
                    held_d[match_idx_q] = 1'b0;
                    if (pedal_q) sust_d[match_idx_q] = 1'b1;
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                if (op_q == OP_SUST) begin
                    pedal_d = op_vel_q[6];
                    if (!op_vel_q[6]) sust_d = '0;
                end else begin
                    held_d  = '0;
                    sust_d  = '0;
                    pedal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < VOICES; i++) begin
            active_d = active_d + (V_WIDTH + 2)'(held_d[i]);
        end
    end

    assign ev.ev_ready     = (state_q == S_IDLE);
    assign ev.assign_valid = assign_valid_q;
    assign ev.assign_voice = assign_voice_q;
    assign ev.assign_key   = assign_key_q;
    assign ev.assign_vel   = assign_vel_q;
    assign ev.assign_steal = assign_steal_q;
    assign keys_on         = held_q;
    assign active_keys     = active_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized event-level reference model bench for voice_allocator
module tb_voice_allocator;
    localparam int VOICES = 32;

    logic        reg_clk = 1'b0;
    logic        reset_reg_n;
    logic [31:0] voice_free;
    logic [31:0] keys_on;
    logic [5:0]  active_keys;

    voice_allocator_if #(.V_WIDTH(4)) bus ();

    voice_allocator #(.VOICES(32), .V_WIDTH(4)) dut (
        .reg_clk     (reg_clk),
        .reset_reg_n (reset_reg_n),
        .ev          (bus),
        .voice_free  (voice_free),
        .keys_on     (keys_on),
        .active_keys (active_keys)
    );

    always #5 reg_clk = ~reg_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] m_key [32];
    int         m_age [32];
    bit  [31:0] m_held;
    bit  [31:0] m_sust;
    bit         m_pedal;

    int         last_voice;
    int         last_steal;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_key[i] = '0;
            m_age[i] = 0;
        end
        m_held  = '0;
        m_sust  = '0;
        m_pedal = 1'b0;
    endtask

    // Applies one event to the reference table; returns the expected assignment, if any.
    task automatic model_apply(input int t, input int k, input int v, input logic [31:0] vf,
                               output bit pulse, output int voice, output int steal);
        int mi, fi, oi, tg;
        pulse = 0; voice = 0; steal = 0;
        if (t == 0 && v == 0) t = 1;
        if (t <= 1) begin
            mi = -1; fi = -1; oi = 0;
            for (int i = 0; i < 32; i++) begin
                if (mi < 0 && int'(m_key[i]) == k && (m_held[i] || m_sust[i])) mi = i;
                if (fi < 0 && vf[i] && !m_held[i] && !m_sust[i]) fi = i;
                if (m_age[i] > m_age[oi]) oi = i;
            end
            if (t == 0) begin
                tg    = (mi >= 0) ? mi : ((fi >= 0) ? fi : oi);
                steal = (mi < 0 && fi < 0) ? 1 : 0;
                for (int i = 0; i < 32; i++)
                    if ((m_held[i] || m_sust[i]) && m_age[i] < VOICES - 1) m_age[i]++;
                m_key[tg]  = 7'(k);
                m_held[tg] = 1'b1;
                m_sust[tg] = 1'b0;
                m_age[tg]  = 0;
                pulse = 1;
                voice = tg;
            end else if (mi >= 0) begin
                m_held[mi] = 1'b0;
                if (m_pedal) m_sust[mi] = 1'b1;
            end
        end else if (t == 2) begin
            if (v >= 64) m_pedal = 1'b1;
            else begin
                m_pedal = 1'b0;
                m_sust  = '0;
            end
        end else begin
            m_held  = '0;
            m_sust  = '0;
            m_pedal = 1'b0;
        end
    endtask

    task automatic do_event(input int t, input int k, input int v, input logic [31:0] vf);
        int  cyc, pulses, pulse_at, span, c_voice, c_key, c_vel, c_steal;
        int  e_voice, e_steal;
        bit  e_pulse;
        cyc = 0;
        while (!bus.ev_ready && cyc < 100) begin
            @(negedge reg_clk);
            cyc++;
        end
        check("ready_before_event", bus.ev_ready, 1);
        voice_free  = vf;
        bus.ev_valid = 1'b1;
        bus.ev_type  = 2'(t);
        bus.ev_key   = 7'(k);
        bus.ev_vel   = 7'(v);
        @(posedge reg_clk);
        @(negedge reg_clk);
        bus.ev_valid = 1'b0;
        bus.ev_type  = 2'($urandom);
        bus.ev_key   = 7'($urandom);
        bus.ev_vel   = 7'($urandom);
        model_apply(t, k, v, vf, e_pulse, e_voice, e_steal);
        span   = (t <= 1) ? VOICES + 3 : 3;
        pulses = 0; pulse_at = -1;
        c_voice = 0; c_key = 0; c_vel = 0; c_steal = 0;
        for (int e = 1; e <= span; e++) begin
            @(negedge reg_clk);
            if (bus.assign_valid) begin
                pulses++;
                pulse_at = e;
                c_voice  = int'(bus.assign_voice);
                c_key    = int'(bus.assign_key);
                c_vel    = int'(bus.assign_vel);
                c_steal  = int'(bus.assign_steal);
            end
            if (t <= 1 && e == VOICES)     check("ready_low_in_scan", bus.ev_ready, 0);
            if (t <= 1 && e == VOICES + 1) check("ready_after_commit", bus.ev_ready, 1);
            if (t >= 2 && e == 1)          check("ready_after_apply", bus.ev_ready, 1);
        end
        check("assign_pulses", pulses, e_pulse ? 1 : 0);
        if (e_pulse) begin
            check("assign_latency", pulse_at, VOICES + 1);
            check("assign_voice", c_voice, e_voice);
            check("assign_key", c_key, k);
            check("assign_vel", c_vel, v);
            check("assign_steal", c_steal, e_steal);
            last_voice = c_voice;
            last_steal = c_steal;
        end
        check("keys_on", keys_on, m_held);
        check("active_keys", active_keys, $countones(m_held));
    endtask

    initial begin
        int pulses, t, k, v, r;
        logic [31:0] vf;
        reset_reg_n  = 1'b0;
        bus.ev_valid = 1'b0;
        bus.ev_type  = '0;
        bus.ev_key   = '0;
        bus.ev_vel   = '0;
        voice_free   = '1;
        last_voice   = -1;
        last_steal   = -1;
        model_reset();
        repeat (3) @(posedge reg_clk);
        #1;
        check("rst_ready", bus.ev_ready, 1);
        check("rst_keys_on", keys_on, 0);
        check("rst_active", active_keys, 0);
        check("rst_assign_valid", bus.assign_valid, 0);
        check("rst_assign_voice", bus.assign_voice, 0);
        @(negedge reg_clk);
        reset_reg_n = 1'b1;
        @(negedge reg_clk);

        do_event(0, 60, 100, '1);
        check("first_voice", last_voice, 0);
        check("first_keys", keys_on, 32'h1);
        check("first_active", active_keys, 1);

        do_event(0, 62, 80, '1);
        check("second_voice", last_voice, 1);
        do_event(0, 64, 70, '1);
        check("third_voice", last_voice, 2);
        do_event(1, 62, 0, '1);
        check("off62_keys", keys_on, 32'h5);
        check("off62_active", active_keys, 2);
        do_event(1, 70, 10, '1);
        check("off70_keys", keys_on, 32'h5);

        do_event(0, 60, 90, '1);
        check("retrig_voice", last_voice, 0);
        check("retrig_active", active_keys, 2);

        do_event(3, 0, 0, '1);
        for (int i = 0; i < 32; i++) do_event(0, i, 100, '1);
        do_event(0, 40, 55, '0);
        check("steal_voice", last_voice, 0);
        check("steal_flag", last_steal, 1);
        check("steal_keys", keys_on, 32'hFFFF_FFFF);

        do_event(3, 0, 0, '1);
        do_event(2, 0, 64, '1);
        do_event(0, 60, 100, '1);
        do_event(1, 60, 30, '1);
        check("sust_gate0", keys_on[0], 0);
        do_event(0, 61, 100, '1);
        check("sust_skip_voice", last_voice, 1);
        do_event(2, 0, 0, '1);
        do_event(0, 62, 100, '1);
        check("sust_release_voice", last_voice, 0);

        bus.ev_valid = 1'b1;
        bus.ev_type  = 2'd0;
        bus.ev_key   = 7'd70;
        bus.ev_vel   = 7'd99;
        @(posedge reg_clk);
        @(negedge reg_clk);
        bus.ev_valid = 1'b0;
        repeat (5) @(posedge reg_clk);
        #2 reset_reg_n = 1'b0;
        #1;
        check("midrst_ready", bus.ev_ready, 1);
        check("midrst_keys", keys_on, 0);
        check("midrst_active", active_keys, 0);
        check("midrst_assign_valid", bus.assign_valid, 0);
        check("midrst_assign_voice", bus.assign_voice, 0);
        check("midrst_assign_key", bus.assign_key, 0);
        check("midrst_assign_vel", bus.assign_vel, 0);
        check("midrst_assign_steal", bus.assign_steal, 0);
        model_reset();
        repeat (2) @(negedge reg_clk);
        reset_reg_n = 1'b1;
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            @(negedge reg_clk);
            if (bus.assign_valid) pulses++;
        end
        check("midrst_no_assign", pulses, 0);
        check("midrst_ready_after", bus.ev_ready, 1);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            t = (r < 50) ? 0 : (r < 80) ? 1 : (r < 95) ? 2 : 3;
            k = 56 + $urandom_range(0, 7);
            v = $urandom_range(1, 127);
            if ($urandom_range(0, 9) == 0) v = 0;
            r = $urandom_range(0, 9);
            vf = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
            do_event(t, k, v, vf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
